// File: rtl/ct_ebiu_snoop_channel.sv
// EBIU snoop channel: buffers ACE snoops, forwards them to ebiuif with a sequence ID
// and returns CR/CD in order; bypass mode answers every snoop locally with a miss.
module ct_ebiu_snoop_channel #(
    parameter int ADDRW     = 40,
    parameter int DATAW     = 128,
    parameter int AC_DEPTH  = 2,
    parameter int CR_DEPTH  = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             snoop_en,
    input  logic             bus_acvalid,
    output logic             bus_acready,
    input  logic [ADDRW-1:0] bus_acaddr,
    input  logic [2:0]       bus_acprot,
    input  logic [3:0]       bus_acsnoop,
    output logic             bus_crvalid,
    input  logic             bus_crready,
    output logic [4:0]       bus_crresp,
    output logic             bus_cdvalid,
    input  logic             bus_cdready,
    output logic [DATAW-1:0] bus_cddata,
    output logic             bus_cdlast,
    output logic             ebiu_ebiuif_acvalid,
    input  logic             ebiuif_ebiu_ac_grant,
    output logic [ADDRW-1:0] ebiu_ebiuif_acaddr,
    output logic [4:0]       ebiu_ebiuif_acid,
    output logic [2:0]       ebiu_ebiuif_acprot,
    output logic [3:0]       ebiu_ebiuif_acsnoop,
    input  logic             ebiuif_ebiu_crvalid,
    input  logic [4:0]       ebiuif_ebiu_crresp,
    output logic             ebiu_ebiuif_cr_grant,
    input  logic             ebiuif_ebiu_cdvalid,
    input  logic [DATAW-1:0] ebiuif_ebiu_cddata,
    input  logic             ebiuif_ebiu_cdlast,
    output logic             ebiu_ebiuif_cd_grant,
    output logic             ebiu_snoop_channel_no_op
);

    localparam int AAW  = $clog2(AC_DEPTH);
    localparam int CAW  = $clog2(CR_DEPTH);
    localparam int OUTW = $clog2(MAX_OUTST + 1);
    localparam logic [OUTW-1:0] OUTST_LIMIT = OUTW'(MAX_OUTST);

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [2:0]       prot;
        logic [3:0]       snoop;
    } ac_entry_t;

    // AC FIFO state
    ac_entry_t        ac_mem [AC_DEPTH];
    logic [AAW:0]     ac_wr_ptr;
    logic [AAW:0]     ac_rd_ptr;
    logic             ac_empty;
    logic             ac_full;
    ac_entry_t        ac_head;
    ac_entry_t        ac_push_data;

    // CR FIFO state
    logic [4:0]       cr_mem [CR_DEPTH];
    logic [CAW:0]     cr_wr_ptr;
    logic [CAW:0]     cr_rd_ptr;
    logic             cr_empty;
    logic             cr_full;
    logic [4:0]       cr_push_data;

    // Tracking and CD slice state
    logic [OUTW-1:0]  outst;
    logic [4:0]       ac_id;
    logic             slice_valid;
    logic [DATAW-1:0] slice_data;
    logic             slice_last;

    logic byp_ready;
    logic ac_handshake;
    logic ac_push;
    logic byp_push;
    logic ac_pop;
    logic cr_push;
    logic cr_pop;
    logic cd_pop;

    assign ac_empty = (ac_wr_ptr == ac_rd_ptr);
    assign ac_full  = (ac_wr_ptr[AAW] != ac_rd_ptr[AAW]) &&
                      (ac_wr_ptr[AAW-1:0] == ac_rd_ptr[AAW-1:0]);
    assign cr_empty = (cr_wr_ptr == cr_rd_ptr);
    assign cr_full  = (cr_wr_ptr[CAW] != cr_rd_ptr[CAW]) &&
                      (cr_wr_ptr[CAW-1:0] == cr_rd_ptr[CAW-1:0]);

    // Bypass only accepts once every forwarded snoop has fully retired, so local
    // misses can never overtake a forwarded response.
    assign byp_ready   = !cr_full && ac_empty && (outst == '0) && !slice_valid;
    assign bus_acready = !cpurst && (snoop_en ? !ac_full : byp_ready);

    assign ac_handshake = bus_acvalid && bus_acready;
    assign ac_push      = ac_handshake && snoop_en;
    assign byp_push     = ac_handshake && !snoop_en;
    assign ac_push_data = '{addr: bus_acaddr, prot: bus_acprot, snoop: bus_acsnoop};

    // Leftover AC entries still drain after a switch to bypass; in steady bypass
    // the AC FIFO stays empty so nothing is forwarded.
    assign ac_head             = ac_empty ? '0 : ac_mem[ac_rd_ptr[AAW-1:0]];
    assign ebiu_ebiuif_acvalid = !ac_empty && (outst < OUTST_LIMIT);
    assign ebiu_ebiuif_acaddr  = ac_head.addr;
    assign ebiu_ebiuif_acprot  = ac_head.prot;
    assign ebiu_ebiuif_acsnoop = ac_head.snoop;
    assign ebiu_ebiuif_acid    = ac_id;
    assign ac_pop              = ebiu_ebiuif_acvalid && ebiuif_ebiu_ac_grant;

    assign ebiu_ebiuif_cr_grant = !cpurst && ebiuif_ebiu_crvalid && !cr_full;
    assign cr_push      = ebiu_ebiuif_cr_grant || byp_push;
    assign cr_push_data = ebiu_ebiuif_cr_grant ? ebiuif_ebiu_crresp : 5'b0;
    assign bus_crvalid  = !cr_empty;
    assign bus_crresp   = cr_empty ? 5'b0 : cr_mem[cr_rd_ptr[CAW-1:0]];
    assign cr_pop       = bus_crvalid && bus_crready;

    assign ebiu_ebiuif_cd_grant = !cpurst && ebiuif_ebiu_cdvalid &&
                                  (!slice_valid || bus_cdready);
    assign cd_pop      = slice_valid && bus_cdready;
    assign bus_cdvalid = slice_valid;
    assign bus_cddata  = slice_data;
    assign bus_cdlast  = slice_last;

    assign ebiu_snoop_channel_no_op = ac_empty && cr_empty && (outst == '0) && !slice_valid;

    // NOTE: all state below updates with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            ac_wr_ptr <= '0;
            ac_rd_ptr <= '0;
            cr_wr_ptr <= '0;
            cr_rd_ptr <= '0;
            outst     <= '0;
            ac_id     <= '0;
        end else begin
            if (ac_push) ac_wr_ptr <= ac_wr_ptr + (AAW+1)'(1);
            if (ac_pop)  ac_rd_ptr <= ac_rd_ptr + (AAW+1)'(1);
            if (cr_push) cr_wr_ptr <= cr_wr_ptr + (CAW+1)'(1);
            if (cr_pop)  cr_rd_ptr <= cr_rd_ptr + (CAW+1)'(1);
            if (ac_pop)  ac_id     <= ac_id + 5'd1;
            case ({ac_pop, ebiu_ebiuif_cr_grant})
                2'b10:   outst <= outst + OUTW'(1);
                2'b01:   outst <= outst - OUTW'(1);
                default: outst <= outst;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; the empty flags mask every read, so stale
    // contents never reach an output and the arrays stay plain RAM.
    always_ff @(posedge forever_cpuclk) begin
        if (ac_push) ac_mem[ac_wr_ptr[AAW-1:0]] <= ac_push_data;
        if (cr_push) cr_mem[cr_wr_ptr[CAW-1:0]] <= cr_push_data;
    end

    // A pop and a push in the same cycle reload the slice with the new beat.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            slice_valid <= 1'b0;
            slice_data  <= '0;
            slice_last  <= 1'b0;
        end else if (ebiu_ebiuif_cd_grant) begin
            slice_valid <= 1'b1;
            slice_data  <= ebiuif_ebiu_cddata;
            slice_last  <= ebiuif_ebiu_cdlast;
        end else if (cd_pop) begin
            slice_valid <= 1'b0;
        end
    end

    // A response granted with nothing outstanding means ebiuif broke the protocol.
    cr_without_snoop: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        !(ebiu_ebiuif_cr_grant && (outst == '0)));

    outst_in_range: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        outst <= OUTST_LIMIT);

endmodule

// File: tb/tb_ct_ebiu_snoop_channel.sv
// Directed bench for ct_ebiu_snoop_channel: reset, forward, back-pressure, bypass,
// mode switches and the CD register slice, all with hand-derived expectations.
module tb_ct_ebiu_snoop_channel;

    localparam int ADDRW = 40;
    localparam int DATAW = 128;

    logic             forever_cpuclk = 1'b0;
    logic             cpurst;
    logic             snoop_en;
    logic             bus_acvalid;
    logic             bus_acready;
    logic [ADDRW-1:0] bus_acaddr;
    logic [2:0]       bus_acprot;
    logic [3:0]       bus_acsnoop;
    logic             bus_crvalid;
    logic             bus_crready;
    logic [4:0]       bus_crresp;
    logic             bus_cdvalid;
    logic             bus_cdready;
    logic [DATAW-1:0] bus_cddata;
    logic             bus_cdlast;
    logic             ebiu_ebiuif_acvalid;
    logic             ebiuif_ebiu_ac_grant;
    logic [ADDRW-1:0] ebiu_ebiuif_acaddr;
    logic [4:0]       ebiu_ebiuif_acid;
    logic [2:0]       ebiu_ebiuif_acprot;
    logic [3:0]       ebiu_ebiuif_acsnoop;
    logic             ebiuif_ebiu_crvalid;
    logic [4:0]       ebiuif_ebiu_crresp;
    logic             ebiu_ebiuif_cr_grant;
    logic             ebiuif_ebiu_cdvalid;
    logic [DATAW-1:0] ebiuif_ebiu_cddata;
    logic             ebiuif_ebiu_cdlast;
    logic             ebiu_ebiuif_cd_grant;
    logic             ebiu_snoop_channel_no_op;

    int n_cmp = 0;
    int n_err = 0;

    ct_ebiu_snoop_channel dut (
        .forever_cpuclk           (forever_cpuclk),
        .cpurst                   (cpurst),
        .snoop_en                 (snoop_en),
        .bus_acvalid              (bus_acvalid),
        .bus_acready              (bus_acready),
        .bus_acaddr               (bus_acaddr),
        .bus_acprot               (bus_acprot),
        .bus_acsnoop              (bus_acsnoop),
        .bus_crvalid              (bus_crvalid),
        .bus_crready              (bus_crready),
        .bus_crresp               (bus_crresp),
        .bus_cdvalid              (bus_cdvalid),
        .bus_cdready              (bus_cdready),
        .bus_cddata               (bus_cddata),
        .bus_cdlast               (bus_cdlast),
        .ebiu_ebiuif_acvalid      (ebiu_ebiuif_acvalid),
        .ebiuif_ebiu_ac_grant     (ebiuif_ebiu_ac_grant),
        .ebiu_ebiuif_acaddr       (ebiu_ebiuif_acaddr),
        .ebiu_ebiuif_acid         (ebiu_ebiuif_acid),
        .ebiu_ebiuif_acprot       (ebiu_ebiuif_acprot),
        .ebiu_ebiuif_acsnoop      (ebiu_ebiuif_acsnoop),
        .ebiuif_ebiu_crvalid      (ebiuif_ebiu_crvalid),
        .ebiuif_ebiu_crresp       (ebiuif_ebiu_crresp),
        .ebiu_ebiuif_cr_grant     (ebiu_ebiuif_cr_grant),
        .ebiuif_ebiu_cdvalid      (ebiuif_ebiu_cdvalid),
        .ebiuif_ebiu_cddata       (ebiuif_ebiu_cddata),
        .ebiuif_ebiu_cdlast       (ebiuif_ebiu_cdlast),
        .ebiu_ebiuif_cd_grant     (ebiu_ebiuif_cd_grant),
        .ebiu_snoop_channel_no_op (ebiu_snoop_channel_no_op)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow one settle step later.
    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [127:0] beat(input int k);
        return {4{32'hC0DE_0000 + 32'(k)}};
    endfunction

    initial begin
        int sent;
        int grants;
        int pops;
        int j;
        int rx;
        int tx;
        logic [3:0] cd_pat;

        // ---------------- reset with every input active ----------------
        cpurst               = 1'b0;
        snoop_en             = 1'b1;
        bus_acvalid          = 1'b1;
        bus_acaddr           = '1;
        bus_acprot           = 3'b111;
        bus_acsnoop          = 4'hF;
        bus_crready          = 1'b1;
        bus_cdready          = 1'b1;
        ebiuif_ebiu_ac_grant = 1'b1;
        ebiuif_ebiu_crvalid  = 1'b1;
        ebiuif_ebiu_crresp   = 5'h1F;
        ebiuif_ebiu_cdvalid  = 1'b1;
        ebiuif_ebiu_cddata   = '1;
        ebiuif_ebiu_cdlast   = 1'b1;
        #1 cpurst = 1'b1;
        #2;
        check("rst_acready",  bus_acready, 0);
        check("rst_acvalid",  ebiu_ebiuif_acvalid, 0);
        check("rst_acid",     ebiu_ebiuif_acid, 0);
        check("rst_acaddr",   ebiu_ebiuif_acaddr, 0);
        check("rst_cr_grant", ebiu_ebiuif_cr_grant, 0);
        check("rst_cd_grant", ebiu_ebiuif_cd_grant, 0);
        check("rst_crvalid",  bus_crvalid, 0);
        check("rst_crresp",   bus_crresp, 0);
        check("rst_cdvalid",  bus_cdvalid, 0);
        check("rst_cddata",   bus_cddata, 0);
        check("rst_cdlast",   bus_cdlast, 0);
        check("rst_no_op",    ebiu_snoop_channel_no_op, 1);

        bus_acvalid          = 1'b0;
        bus_acaddr           = '0;
        bus_acprot           = '0;
        bus_acsnoop          = '0;
        bus_crready          = 1'b0;
        bus_cdready          = 1'b0;
        ebiuif_ebiu_ac_grant = 1'b0;
        ebiuif_ebiu_crvalid  = 1'b0;
        ebiuif_ebiu_crresp   = '0;
        ebiuif_ebiu_cdvalid  = 1'b0;
        ebiuif_ebiu_cddata   = '0;
        ebiuif_ebiu_cdlast   = 1'b0;
        tick();
        tick();
        cpurst = 1'b0;
        settle();
        check("idle_acready", bus_acready, 1);
        check("idle_no_op",   ebiu_snoop_channel_no_op, 1);

        // ---------------- single forwarded snoop ----------------
        tick();
        bus_acvalid = 1'b1;
        bus_acaddr  = 40'h12_3456_7840;
        bus_acprot  = 3'b010;
        bus_acsnoop = 4'b1001;
        settle();
        check("one_acready",   bus_acready, 1);
        check("one_no_early",  ebiu_ebiuif_acvalid, 0);
        tick();
        bus_acvalid = 1'b0;
        settle();
        check("one_acvalid",   ebiu_ebiuif_acvalid, 1);
        check("one_acaddr",    ebiu_ebiuif_acaddr, 40'h12_3456_7840);
        check("one_acid",      ebiu_ebiuif_acid, 0);
        check("one_acprot",    ebiu_ebiuif_acprot, 3'b010);
        check("one_acsnoop",   ebiu_ebiuif_acsnoop, 4'b1001);
        check("one_busy",      ebiu_snoop_channel_no_op, 0);
        ebiuif_ebiu_ac_grant = 1'b1;
        tick();
        ebiuif_ebiu_ac_grant = 1'b0;
        settle();
        check("one_ac_gone",   ebiu_ebiuif_acvalid, 0);
        check("one_outst",     ebiu_snoop_channel_no_op, 0);
        ebiuif_ebiu_crvalid = 1'b1;
        ebiuif_ebiu_crresp  = 5'b00001;
        settle();
        check("one_cr_grant",  ebiu_ebiuif_cr_grant, 1);
        tick();
        ebiuif_ebiu_crvalid = 1'b0;
        settle();
        check("one_crvalid",   bus_crvalid, 1);
        check("one_crresp",    bus_crresp, 5'b00001);
        bus_crready = 1'b1;
        tick();
        bus_crready = 1'b0;
        settle();
        check("one_cr_done",   bus_crvalid, 0);
        check("one_no_op",     ebiu_snoop_channel_no_op, 1);

        // ---------------- reset pulsed mid-traffic ----------------
        bus_acvalid = 1'b1;
        bus_acaddr  = 40'hAA_0000_0000;
        tick();
        bus_acaddr  = 40'hAA_0000_0040;
        tick();
        bus_acvalid = 1'b0;
        ebiuif_ebiu_ac_grant = 1'b1;
        settle();
        check("mid_acid1",     ebiu_ebiuif_acid, 1);
        check("mid_full",      bus_acready, 0);
        tick();
        ebiuif_ebiu_ac_grant = 1'b0;
        settle();
        check("mid_acid2",     ebiu_ebiuif_acid, 2);
        #1 cpurst = 1'b1;
        #1;
        check("mid_rst_no_op",   ebiu_snoop_channel_no_op, 1);
        check("mid_rst_acvalid", ebiu_ebiuif_acvalid, 0);
        check("mid_rst_acid",    ebiu_ebiuif_acid, 0);
        check("mid_rst_acready", bus_acready, 0);
        check("mid_rst_crvalid", bus_crvalid, 0);
        tick();
        cpurst = 1'b0;
        settle();
        check("mid_post_acready", bus_acready, 1);

        // ---------------- six back-to-back snoops, no CRs ----------------
        ebiuif_ebiu_ac_grant = 1'b1;
        sent   = 0;
        grants = 0;
        for (int c = 0; c < 12; c++) begin
            bus_acvalid = (sent < 6);
            bus_acaddr  = 40'h55_0000_0000 + 40'(sent * 64);
            settle();
            if (ebiu_ebiuif_acvalid) begin
                check("fill_acid",   ebiu_ebiuif_acid, 128'(grants));
                check("fill_acaddr", ebiu_ebiuif_acaddr, 40'h55_0000_0000 + 40'(grants * 64));
                grants++;
            end
            if (bus_acvalid && bus_acready) sent++;
            tick();
        end
        bus_acvalid = 1'b0;
        settle();
        check("fill_grants",   grants, 4);
        check("fill_sent",     sent, 6);
        check("fill_acready",  bus_acready, 0);
        check("fill_stalled",  ebiu_ebiuif_acvalid, 0);

        // ---------------- release four CRs ----------------
        bus_crready = 1'b1;
        j    = 0;
        pops = 0;
        for (int c = 0; c < 12; c++) begin
            ebiuif_ebiu_crvalid = (j < 4);
            ebiuif_ebiu_crresp  = 5'(16 + j);
            settle();
            if (ebiu_ebiuif_acvalid) begin
                check("rel_acid",   ebiu_ebiuif_acid, 128'(grants));
                check("rel_acaddr", ebiu_ebiuif_acaddr, 40'h55_0000_0000 + 40'(grants * 64));
                grants++;
            end
            if (bus_crvalid) begin
                check("rel_crresp", bus_crresp, 128'(16 + pops));
                pops++;
            end
            if (ebiu_ebiuif_cr_grant) j++;
            tick();
        end
        ebiuif_ebiu_crvalid  = 1'b0;
        ebiuif_ebiu_ac_grant = 1'b0;
        bus_crready          = 1'b0;
        settle();
        check("rel_cr_grants", j, 4);
        check("rel_pops",      pops, 4);
        check("rel_grants",    grants, 6);
        check("rel_busy",      ebiu_snoop_channel_no_op, 0);
        check("rel_cr_empty",  bus_crvalid, 0);

        // ---------------- FWD -> BYP with two snoops outstanding ----------------
        snoop_en            = 1'b0;
        bus_acvalid         = 1'b1;
        ebiuif_ebiu_crvalid = 1'b1;
        ebiuif_ebiu_crresp  = 5'b01001;
        settle();
        check("sw_acready_0",  bus_acready, 0);
        check("sw_grant_0",    ebiu_ebiuif_cr_grant, 1);
        tick();
        ebiuif_ebiu_crresp  = 5'b01011;
        settle();
        check("sw_acready_1",  bus_acready, 0);
        check("sw_grant_1",    ebiu_ebiuif_cr_grant, 1);
        tick();
        ebiuif_ebiu_crvalid = 1'b0;
        bus_crready         = 1'b1;
        settle();
        check("sw_acready_2",  bus_acready, 0);
        check("sw_resp_0",     bus_crresp, 5'b01001);
        tick();
        settle();
        check("sw_acready_3",  bus_acready, 1);
        check("sw_resp_1",     bus_crresp, 5'b01011);
        tick();
        settle();
        check("sw_miss_0v",    bus_crvalid, 1);
        check("sw_miss_0",     bus_crresp, 5'b0);
        check("sw_no_fwd",     ebiu_ebiuif_acvalid, 0);
        tick();
        bus_acvalid = 1'b0;
        settle();
        check("sw_miss_1v",    bus_crvalid, 1);
        check("sw_miss_1",     bus_crresp, 5'b0);
        tick();
        settle();
        check("sw_drained",    bus_crvalid, 0);
        check("sw_no_op",      ebiu_snoop_channel_no_op, 1);

        // ---------------- bypass, three snoops ----------------
        sent = 0;
        pops = 0;
        for (int c = 0; c < 8; c++) begin
            bus_acvalid = (sent < 3);
            settle();
            check("byp_no_fwd", ebiu_ebiuif_acvalid, 0);
            if (bus_crvalid) begin
                check("byp_crresp", bus_crresp, 5'b0);
                pops++;
            end
            if (bus_acvalid && bus_acready) sent++;
            tick();
        end
        bus_acvalid = 1'b0;
        settle();
        check("byp_sent",      sent, 3);
        check("byp_pops",      pops, 3);
        check("byp_no_op",     ebiu_snoop_channel_no_op, 1);

        // ---------------- BYP -> FWD takes effect immediately ----------------
        bus_crready = 1'b0;
        bus_acvalid = 1'b1;
        tick();
        tick();
        settle();
        check("b2f_byp_stall", bus_acready, 0);
        snoop_en = 1'b1;
        settle();
        check("b2f_fwd_ready", bus_acready, 1);
        bus_acvalid = 1'b0;
        bus_crready = 1'b1;
        tick();
        tick();
        bus_crready = 1'b0;
        settle();
        check("b2f_no_op",     ebiu_snoop_channel_no_op, 1);

        // ---------------- CD burst with bus_cdready 1,0,1,1 ----------------
        cd_pat = 4'b1101;
        rx = 0;
        tx = 0;
        for (int c = 0; c < 10; c++) begin
            ebiuif_ebiu_cdvalid = (tx < 4);
            ebiuif_ebiu_cddata  = beat(tx);
            ebiuif_ebiu_cdlast  = (tx == 3);
            bus_cdready         = (c < 4) ? cd_pat[c] : 1'b1;
            settle();
            if (bus_cdvalid && bus_cdready) begin
                check("cd_data", bus_cddata, beat(rx));
                check("cd_last", bus_cdlast, 128'(rx == 3));
                rx++;
            end
            if (ebiu_ebiuif_cd_grant) tx++;
            tick();
        end
        ebiuif_ebiu_cdvalid = 1'b0;
        settle();
        check("cd_rx",         rx, 4);
        check("cd_tx",         tx, 4);
        check("cd_empty",      bus_cdvalid, 0);
        check("cd_no_op",      ebiu_snoop_channel_no_op, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
